// File: rtl/sram_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// sram_fifo_ctrl
//   Streaming valid/ready FIFO built around a 1024x64 two-port SRAM macro.
//   Pushes are written to the macro write port. Words are prefetched from the
//   read port into a 2-entry registered output buffer, and the head of that
//   buffer drives out_data/out_valid.
//
//   Optional feature (compile-time macro SRAM_FIFO_BYPASS_EN):
//     When the macro is defined, a push that finds the SRAM and the read
//     pipeline empty is written straight into the output buffer, so the word
//     appears one cycle later. When it is undefined, every word passes through
//     the SRAM and no bypass logic exists.
//
// Ports
//   clk, rst              clock (also the macro clock); synchronous active-high reset
//   in_valid/in_ready     push handshake, in_data is the push word
//   out_valid/out_ready   pop handshake, out_data is the registered head word
//   level                 words held: SRAM + read in flight + output buffer
//   sram_aa/d/bweb/web    macro write port (web is active-low)
//   sram_ab/reb/q         macro read port (reb is active-low, q valid the
//                         cycle after the read)
//   sram_rtsel/wtsel/mtsel  timing selects, tied to TSEL
// -----------------------------------------------------------------------------
module sram_fifo_ctrl #(
  parameter int          DW   = 64,
  parameter int          AW   = 10,
  parameter logic [1:0]  TSEL = 2'b01
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW+1:0] level,
  output logic [AW-1:0] sram_aa,
  output logic [DW-1:0] sram_d,
  output logic [DW-1:0] sram_bweb,
  output logic          sram_web,
  output logic [AW-1:0] sram_ab,
  output logic          sram_reb,
  input  logic [DW-1:0] sram_q,
  output logic [1:0]    sram_rtsel,
  output logic [1:0]    sram_wtsel,
  output logic [1:0]    sram_mtsel
);

  // mem_cnt needs one extra bit to represent a completely full macro
  localparam logic [AW:0] MEM_FULL = {1'b1, {AW{1'b0}}};

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   mem_cnt_q, mem_cnt_d;     // words written and not yet read
  logic          rd_inflight_q, rd_inflight_d;
  logic [1:0]    obuf_cnt_q, obuf_cnt_d;   // output buffer occupancy, 0..2
  logic [DW-1:0] head_q, head_d;           // output buffer entry 0 (drives out_data)
  logic [DW-1:0] tail_q, tail_d;           // output buffer entry 1
  logic [AW+1:0] level_q, level_d;

  // ---------------------------------------------------------------------------
  // Handshake / control
  // ---------------------------------------------------------------------------
  logic          push;        // accepted push
  logic          push_sram;   // accepted push that is written to the macro
  logic          pop;         // accepted pop
  logic          rd_issue;    // read issued to the macro this cycle
  logic [2:0]    occ;         // buffer entries committed after this cycle's pop
  logic [1:0]    obuf_left;   // buffer occupancy after this cycle's pop
  logic          ld_en;       // a word is written into the output buffer
  logic [DW-1:0] ld_word;
`ifdef SRAM_FIFO_BYPASS_EN
  logic          byp;         // push goes straight to the output buffer
`endif

  always_comb begin
    out_valid = (obuf_cnt_q != 2'd0);
    pop       = out_valid && out_ready;
    in_ready  = !rst && (mem_cnt_q < MEM_FULL);
    push      = in_valid && in_ready;

    // Count the read in flight as a used slot so a prefetch never overruns
    // the 2-entry buffer. A pop in the same cycle frees a slot right away,
    // which keeps 1 word/cycle streaming going.
    occ       = {1'b0, obuf_cnt_q} + {2'b00, rd_inflight_q} - {2'b00, pop};
    // mem_cnt only counts writes from earlier cycles, so a read never
    // targets the address being written in the same cycle.
    rd_issue  = !rst && (mem_cnt_q != '0) && (occ < 3'd2);

`ifdef SRAM_FIFO_BYPASS_EN
    // Bypass only when nothing older sits in the SRAM or the read pipe, so
    // ordering is kept. rd_issue is 0 in that case (mem_cnt==0).
    byp       = push && (mem_cnt_q == '0) && !rd_inflight_q && (occ < 3'd2);
    push_sram = push && !byp;
    ld_en     = rd_inflight_q || byp;
    ld_word   = rd_inflight_q ? sram_q : in_data;
`else
    push_sram = push;
    ld_en     = rd_inflight_q;
    ld_word   = sram_q;
`endif
  end

  // ---------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------
  always_comb begin
    wptr_d        = wptr_q;
    rptr_d        = rptr_q;
    mem_cnt_d     = mem_cnt_q;
    rd_inflight_d = rd_issue;
    level_d       = level_q;
    head_d        = head_q;
    tail_d        = tail_q;
    obuf_left     = obuf_cnt_q - {1'b0, pop};

    // Pointers wrap naturally at 2**AW
    if (push_sram) wptr_d = wptr_q + 1'b1;
    if (rd_issue)  rptr_d = rptr_q + 1'b1;

    unique case ({push_sram, rd_issue})
      2'b10:   mem_cnt_d = mem_cnt_q + 1'b1;
      2'b01:   mem_cnt_d = mem_cnt_q - 1'b1;
      default: mem_cnt_d = mem_cnt_q;
    endcase

    unique case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    // Output buffer: shift on pop, then load at the first free slot.
    // The head is left untouched when the buffer drains, so out_data keeps
    // showing the last word while out_valid is low.
    if (pop && (obuf_cnt_q == 2'd2)) head_d = tail_q;
    if (ld_en) begin
      if (obuf_left == 2'd0) head_d = ld_word;
      else                   tail_d = ld_word;
    end
    obuf_cnt_d = obuf_left + {1'b0, ld_en};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q        <= '0;
      rptr_q        <= '0;
      mem_cnt_q     <= '0;
      rd_inflight_q <= 1'b0;   // drops any read in flight
      obuf_cnt_q    <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      level_q       <= '0;
    end else begin
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      mem_cnt_q     <= mem_cnt_d;
      rd_inflight_q <= rd_inflight_d;
      obuf_cnt_q    <= obuf_cnt_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      level_q       <= level_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign out_data   = head_q;
  assign level      = level_q;

  assign sram_aa    = wptr_q;
  assign sram_d     = in_data;
  assign sram_bweb  = '0;
  assign sram_web   = !push_sram;
  assign sram_ab    = rptr_q;
  assign sram_reb   = !rd_issue;
  assign sram_rtsel = TSEL;
  assign sram_wtsel = TSEL;
  assign sram_mtsel = TSEL;

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sram_fifo_ctrl
//   Bench for sram_fifo_ctrl (default build, all words pass through the SRAM).
//   It contains a behavioural model of the 1024x64 macro, a table of
//   single-cycle vectors with hand-computed expectations, and directed
//   sequences for fill/full, streaming, random traffic and mid-stream reset.
// -----------------------------------------------------------------------------
module tb_sram_fifo_ctrl;
  localparam int DW = 64;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [DW-1:0] in_data, out_data;
  logic [AW+1:0] level;
  logic [AW-1:0] sram_aa, sram_ab;
  logic [DW-1:0] sram_d, sram_bweb, sram_q;
  logic          sram_web, sram_reb;
  logic [1:0]    sram_rtsel, sram_wtsel, sram_mtsel;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_fifo_ctrl #(.DW(DW), .AW(AW), .TSEL(2'b01)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .level(level),
    .sram_aa(sram_aa), .sram_d(sram_d), .sram_bweb(sram_bweb), .sram_web(sram_web),
    .sram_ab(sram_ab), .sram_reb(sram_reb), .sram_q(sram_q),
    .sram_rtsel(sram_rtsel), .sram_wtsel(sram_wtsel), .sram_mtsel(sram_mtsel)
  );

  // Macro model: synchronous write, registered read data
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (!sram_web) mem[sram_aa] <= (mem[sram_aa] & sram_bweb) | (sram_d & ~sram_bweb);
    if (!sram_reb) sram_q <= mem[sram_ab];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: checks pop order/data and level against its own count
  logic          sb_en = 1'b0;
  logic [DW-1:0] sb [$];
  always @(negedge clk) begin
    logic [DW-1:0] e;
    if (sb_en) begin
      chk("sb_level", 64'(level), 64'(sb.size()));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL sb_pop_empty: got pop of %h expected no word", out_data);
        end else begin
          e = sb.pop_front();
          chk("sb_data", out_data, e);
        end
      end
      if (in_valid && in_ready) sb.push_back(in_data);
    end
    if (!sram_web && !sram_reb) chk("aa_ne_ab", 64'(sram_aa == sram_ab), 64'd0);
  end

  typedef struct {
    logic        rst, iv;
    logic [63:0] din;
    logic        ordy;
    logic        e_ir, e_ov;
    logic [63:0] e_od;
    logic [11:0] e_lvl;
    logic        e_web, e_reb;
    logic [9:0]  e_aa, e_ab;
  } vec_t;

  vec_t vt [13];

  initial begin
    int acc, exp_i, seen, bubbles, seq, n;
    logic [63:0] A5 = 64'hA5A5_0000_0000_0001;

    //           rst iv din       ordy ir ov od       lvl web reb aa ab
    vt[0]  = '{1, 0, 64'h0,    1,  0, 0, 64'h0,    0,  1, 1, 0, 0};
    vt[1]  = '{0, 1, A5,       1,  1, 0, 64'h0,    0,  0, 1, 0, 0};
    vt[2]  = '{0, 0, 64'h0,    1,  1, 0, 64'h0,    1,  1, 0, 1, 0};
    vt[3]  = '{0, 0, 64'h0,    1,  1, 0, 64'h0,    1,  1, 1, 1, 1};
    vt[4]  = '{0, 0, 64'h0,    1,  1, 1, A5,       1,  1, 1, 1, 1};
    vt[5]  = '{0, 0, 64'h0,    0,  1, 0, A5,       0,  1, 1, 1, 1};
    vt[6]  = '{0, 1, 64'h11,   0,  1, 0, A5,       0,  0, 1, 1, 1};
    vt[7]  = '{0, 1, 64'h22,   0,  1, 0, A5,       1,  0, 0, 2, 1};
    vt[8]  = '{0, 0, 64'h0,    0,  1, 0, A5,       2,  1, 0, 3, 2};
    vt[9]  = '{0, 0, 64'h0,    0,  1, 1, 64'h11,   2,  1, 1, 3, 3};
    vt[10] = '{0, 0, 64'h0,    1,  1, 1, 64'h11,   2,  1, 1, 3, 3};
    vt[11] = '{0, 0, 64'h0,    1,  1, 1, 64'h22,   1,  1, 1, 3, 3};
    vt[12] = '{0, 0, 64'h0,    0,  1, 0, 64'h22,   0,  1, 1, 3, 3};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    step();

    // ---- Table: reset state, first-word latency, two-word ordering ----
    for (int i = 0; i < 13; i++) begin
      rst = vt[i].rst; in_valid = vt[i].iv; in_data = vt[i].din; out_ready = vt[i].ordy;
      @(negedge clk);
      chk($sformatf("v%0d_in_ready", i),  64'(in_ready),  64'(vt[i].e_ir));
      chk($sformatf("v%0d_out_valid", i), 64'(out_valid), 64'(vt[i].e_ov));
      chk($sformatf("v%0d_out_data", i),  out_data,       vt[i].e_od);
      chk($sformatf("v%0d_level", i),     64'(level),     64'(vt[i].e_lvl));
      chk($sformatf("v%0d_web", i),       64'(sram_web),  64'(vt[i].e_web));
      chk($sformatf("v%0d_reb", i),       64'(sram_reb),  64'(vt[i].e_reb));
      chk($sformatf("v%0d_aa", i),        64'(sram_aa),   64'(vt[i].e_aa));
      chk($sformatf("v%0d_ab", i),        64'(sram_ab),   64'(vt[i].e_ab));
      step();
    end
    chk("tsel", 64'({sram_rtsel, sram_wtsel, sram_mtsel}), 64'h15);
    chk("bweb", sram_bweb, 64'h0);

    // ---- Fill to full with out_ready=0 ----
    in_valid = 1'b0; out_ready = 1'b0; step();
    acc = 0;
    for (int c = 0; c < 1100; c++) begin
      in_valid = 1'b1; in_data = 64'(acc);
      @(negedge clk);
      if (in_ready) acc++;
      step();
    end
    in_valid = 1'b0;
    step(); step();
    @(negedge clk);
    chk("fill_accepted", 64'(acc), 64'd1026);
    chk("fill_level", 64'(level), 64'd1026);
    chk("fill_in_ready", 64'(in_ready), 64'd0);
    chk("fill_out_valid", 64'(out_valid), 64'd1);
    step();

    // ---- Full: pop and push together, push must be rejected ----
    in_valid = 1'b1; in_data = 64'hDEAD; out_ready = 1'b1;
    @(negedge clk);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    chk("full_head", out_data, 64'd0);
    chk("full_web", 64'(sram_web), 64'd1);
    chk("full_refill_reb", 64'(sram_reb), 64'd0);
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    chk("refill_in_ready", 64'(in_ready), 64'd1);
    chk("refill_level", 64'(level), 64'd1025);
    step();

    // ---- Drain remaining words 1..1025 ----
    out_ready = 1'b1; exp_i = 1;
    for (int c = 0; c < 1200 && exp_i < 1026; c++) begin
      @(negedge clk);
      if (out_valid) begin
        if (out_data !== 64'(exp_i)) chk("drain_data", out_data, 64'(exp_i));
        else checks++;
        exp_i++;
      end
      step();
    end
    chk("drain_count", 64'(exp_i), 64'd1026);
    step();
    @(negedge clk);
    chk("drain_level", 64'(level), 64'd0);
    chk("drain_out_valid", 64'(out_valid), 64'd0);
    step();

    // ---- Streaming: push and pop every cycle ----
    sb_en = 1'b1; seq = 0; seen = 0; bubbles = 0;
    for (int c = 0; c < 3000; c++) begin
      in_valid = 1'b1; in_data = 64'(seq); out_ready = 1'b1;
      @(negedge clk);
      if (in_ready) seq++;
      if (out_valid) seen = 1;
      else if (seen != 0) bubbles++;
      step();
    end
    in_valid = 1'b0;
    chk("stream_pushes", 64'(seq), 64'd3000);
    chk("stream_bubbles", 64'(bubbles), 64'd0);
    n = 0;
    while (n < 50 && (sb.size() != 0 || out_valid)) begin step(); n++; end
    chk("stream_drained", 64'(sb.size()), 64'd0);

    // ---- Random traffic against the scoreboard ----
    for (int c = 0; c < 20000; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_data   = {$urandom, $urandom};
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n = 0;
    while (n < 1200 && (sb.size() != 0 || out_valid)) begin step(); n++; end
    chk("random_drained", 64'(sb.size()), 64'd0);
    step();
    @(negedge clk);
    sb_en = 1'b0;
    step();

    // ---- Mid-stream reset with a read in flight ----
    out_ready = 1'b0; acc = 0;
    for (int c = 0; c < 700 && acc < 600; c++) begin
      in_valid = 1'b1; in_data = 64'(acc + 5000);
      @(negedge clk);
      if (in_ready) acc++;
      step();
    end
    in_valid = 1'b0;
    step(); step(); step();
    out_ready = 1'b1;          // pop frees a slot, refill read is issued
    @(negedge clk);
    chk("rst_prep_reb", 64'(sram_reb), 64'd0);
    step();
    rst = 1'b1; out_ready = 1'b0; in_valid = 1'b1; in_data = 64'h9999;
    @(negedge clk);
    chk("rst_cycle_web", 64'(sram_web), 64'd1);
    chk("rst_cycle_reb", 64'(sram_reb), 64'd1);
    chk("rst_cycle_in_ready", 64'(in_ready), 64'd0);
    step();
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_out_valid", 64'(out_valid), 64'd0);
    chk("post_rst_level", 64'(level), 64'd0);
    chk("post_rst_web", 64'(sram_web), 64'd1);
    chk("post_rst_reb", 64'(sram_reb), 64'd1);
    step();
    in_valid = 1'b1; in_data = 64'h1234;
    step();
    in_valid = 1'b0; out_ready = 1'b1;
    n = 0;
    while (n < 10 && !out_valid) begin step(); n++; end
    @(negedge clk);
    chk("post_rst_valid", 64'(out_valid), 64'd1);
    chk("post_rst_first", out_data, 64'h1234);
    step();
    @(negedge clk);
    chk("post_rst_only_one", 64'(out_valid), 64'd0);
    chk("post_rst_level0", 64'(level), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
